hssl_link_watchdog: RTL and testbench

- Multi-link supervisor for the HSSL transceiver datapath resets.
- Replaces the single fixed handshake-timeout reset generator with NUM_LINKS independent per-link state machines.
- Each link has an enable mask, a forced-reset request, exponential timeout backoff, post-reset hold-off, and saturating retry counters.
- Sits between the link handshake logic and each transceiver's tx/rx datapath soft-reset inputs, in the free-running clock domain.

---
 rtl/hssl_link_watchdog.sv | 158 +++++++++++++++
 tb/tb_hssl_link_watchdog.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hssl_link_watchdog.sv
// Per-link HSSL datapath reset supervisor: handshake timeout with exponential
// backoff, forced resets, post-reset hold-off and saturating retry counters.
module hssl_link_watchdog #(
    parameter int NUM_LINKS         = 4,
    parameter int TIMEOUT_CYCLES    = 75000000,
    parameter int PULSE_LEN         = 16,
    parameter int HOLDOFF_CYCLES    = 1024,
    parameter int MAX_BACKOFF_SHIFT = 3,
    parameter int RETRY_CNT_BITS    = 8
) (
    input  logic                                freerun_clk_in,
    input  logic                                reset_all_n_in,
    input  logic [NUM_LINKS-1:0]                link_enable_in,
    input  logic [NUM_LINKS-1:0]                handshake_complete_in,
    input  logic [NUM_LINKS-1:0]                force_reset_in,
    input  logic                                clear_cnt_in,
    output logic [NUM_LINKS-1:0]                link_reset_out,
    output logic [NUM_LINKS-1:0]                link_up_out,
    output logic [NUM_LINKS*RETRY_CNT_BITS-1:0] retry_cnt_out
);

    localparam int TW   = $clog2((TIMEOUT_CYCLES << MAX_BACKOFF_SHIFT) + 1);
    localparam int CMAX = (PULSE_LEN > HOLDOFF_CYCLES) ? PULSE_LEN : HOLDOFF_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int SW   = (MAX_BACKOFF_SHIFT > 0) ? $clog2(MAX_BACKOFF_SHIFT + 1) : 1;
    localparam int RB   = RETRY_CNT_BITS;

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_WAIT,
        ST_UP,
        ST_PULSE,
        ST_HOLDOFF
    } state_e;

    state_e            state_q [NUM_LINKS];
    state_e            state_d [NUM_LINKS];
    logic [TW-1:0]     timer_q [NUM_LINKS];
    logic [TW-1:0]     timer_d [NUM_LINKS];
    logic [TW-1:0]     limit   [NUM_LINKS];
    logic [CW-1:0]     cnt_q   [NUM_LINKS];
    logic [CW-1:0]     cnt_d   [NUM_LINKS];
    logic [SW-1:0]     shift_q [NUM_LINKS];
    logic [SW-1:0]     shift_d [NUM_LINKS];
    logic [RB-1:0]     retry_q [NUM_LINKS];
    logic [RB-1:0]     retry_d [NUM_LINKS];
    logic              inc     [NUM_LINKS];
    logic [NUM_LINKS-1:0] rst_q, rst_d;
    logic [NUM_LINKS-1:0] up_q, up_d;

    always_comb begin
        rst_d = '0;
        up_d  = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = '0;
            cnt_d[i]   = '0;
            shift_d[i] = shift_q[i];
            retry_d[i] = retry_q[i];
            inc[i]     = 1'b0;
            limit[i]   = (TW'(TIMEOUT_CYCLES) << shift_q[i]) - TW'(1);

            case (state_q[i])
                ST_DISABLED: begin
                    if (link_enable_in[i]) state_d[i] = ST_WAIT;
                end
                ST_WAIT: begin
                    if (!link_enable_in[i]) begin
                        state_d[i] = ST_DISABLED;
                    end else if (force_reset_in[i]) begin
                        state_d[i] = ST_PULSE;
                    end else if (handshake_complete_in[i]) begin
                        state_d[i] = ST_UP;
                        shift_d[i] = '0;
                    end else if (timer_q[i] == limit[i]) begin
                        state_d[i] = ST_PULSE;
                        inc[i]     = 1'b1;
                        if (shift_q[i] != SW'(MAX_BACKOFF_SHIFT))
                            shift_d[i] = shift_q[i] + SW'(1);
                    end else begin
                        timer_d[i] = timer_q[i] + TW'(1);
                    end
                end
                ST_UP: begin
                    if (!link_enable_in[i]) begin
                        state_d[i] = ST_DISABLED;
                    end else if (force_reset_in[i]) begin
                        state_d[i] = ST_PULSE;
                    end else if (!handshake_complete_in[i]) begin
                        state_d[i] = ST_WAIT;
                        shift_d[i] = '0;
                    end
                end
                ST_PULSE: begin
                    if (!link_enable_in[i]) begin
                        state_d[i] = ST_DISABLED;
                    end else if (cnt_q[i] == CW'(PULSE_LEN - 1)) begin
                        state_d[i] = ST_HOLDOFF;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (!link_enable_in[i]) begin
                        state_d[i] = ST_DISABLED;
                    end else if (cnt_q[i] == CW'(HOLDOFF_CYCLES - 1)) begin
                        state_d[i] = ST_WAIT;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: state_d[i] = ST_DISABLED;
            endcase

            // Clear beats a same-cycle increment.
            if (clear_cnt_in)
                retry_d[i] = '0;
            else if (inc[i] && (retry_q[i] != '1))
                retry_d[i] = retry_q[i] + RB'(1);

            rst_d[i] = (state_d[i] == ST_PULSE);
            up_d[i]  = (state_d[i] == ST_UP);
        end
    end

    always_ff @(posedge freerun_clk_in) begin
        if (!reset_all_n_in) begin
            for (int i = 0; i < NUM_LINKS; i++) begin
                state_q[i] <= ST_DISABLED;
                timer_q[i] <= '0;
                cnt_q[i]   <= '0;
                shift_q[i] <= '0;
                retry_q[i] <= '0;
            end
            rst_q <= '0;
            up_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LINKS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                cnt_q[i]   <= cnt_d[i];
                shift_q[i] <= shift_d[i];
                retry_q[i] <= retry_d[i];
            end
            rst_q <= rst_d;
            up_q  <= up_d;
        end
    end

    always_comb begin
        link_reset_out = rst_q;
        link_up_out    = up_q;
        retry_cnt_out  = '0;
        for (int i = 0; i < NUM_LINKS; i++)
            retry_cnt_out[i*RB +: RB] = retry_q[i];
    end

endmodule

// File: tb/tb_hssl_link_watchdog.sv
// Directed bench for hssl_link_watchdog: timeout, backoff, force, hold-off,
// disable, reset, counter clear and link independence.
module tb_hssl_link_watchdog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] en, hs, frc;
    logic       clr;
    logic [1:0] rst_out, up_out;
    logic [5:0] retry;

    int checks = 0;
    int failures = 0;
    int n;

    hssl_link_watchdog #(
        .NUM_LINKS(2), .TIMEOUT_CYCLES(100), .PULSE_LEN(4),
        .HOLDOFF_CYCLES(10), .MAX_BACKOFF_SHIFT(2), .RETRY_CNT_BITS(3)
    ) dut (
        .freerun_clk_in        (clk),
        .reset_all_n_in        (rst_n),
        .link_enable_in        (en),
        .handshake_complete_in (hs),
        .force_reset_in        (frc),
        .clear_cnt_in          (clr),
        .link_reset_out        (rst_out),
        .link_up_out           (up_out),
        .retry_cnt_out         (retry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sel(input int which);
        return (which == 0) ? rst_out[0] : up_out[0];
    endfunction

    // Steps until the selected output reaches val; gives up after bound.
    task automatic wait_for(input int which, input logic val,
                            input int bound, output int cnt);
        cnt = 0;
        while (sel(which) != val && cnt < bound) begin
            step(1);
            cnt++;
        end
    endtask

    localparam int IV [7] = '{210, 410, 410, 410, 410, 410, 410};

    initial begin
        rst_n = 1'b0; en = 2'b00; hs = 2'b00; frc = 2'b00; clr = 1'b0;
        step(2);
        chk("reset_rst_out", rst_out, 0);
        chk("reset_up_out", up_out, 0);
        chk("reset_retry", retry, 0);

        rst_n = 1'b1; en = 2'b11; hs = 2'b10;
        wait_for(0, 1'b1, 1000, n);
        chk("first_timeout", n, 101);
        chk("link1_up", up_out[1], 1);
        wait_for(0, 1'b0, 100, n);
        chk("pulse_len", n, 4);
        chk("retry_1", retry[2:0], 1);

        for (int k = 0; k < 7; k++) begin
            wait_for(0, 1'b1, 1000, n);
            chk($sformatf("interval_%0d", k + 2), n, IV[k]);
            wait_for(0, 1'b0, 100, n);
            chk($sformatf("pulse_len_%0d", k + 2), n, 4);
            chk($sformatf("retry_%0d", k + 2), retry[2:0], (k + 2 > 7) ? 7 : k + 2);
            chk($sformatf("indep_up_%0d", k + 2), up_out[1], 1);
            chk($sformatf("indep_rst_%0d", k + 2), {rst_out[1], retry[5:3]}, 0);
        end

        step(10);
        hs[0] = 1'b1;
        step(1);
        chk("hs_up", up_out[0], 1);
        hs[0] = 1'b0;
        wait_for(0, 1'b1, 1000, n);
        chk("timeout_after_up", n, 101);
        chk("retry_sat", retry[2:0], 7);
        wait_for(0, 1'b0, 100, n);
        step(10);
        hs[0] = 1'b1;
        step(1);
        chk("up_again", up_out[0], 1);

        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clear_cnt", retry[2:0], 0);
        frc[0] = 1'b1;
        step(1);
        frc[0] = 1'b0;
        chk("force_rise", rst_out[0], 1);
        chk("force_not_up", up_out[0], 0);
        wait_for(0, 1'b0, 100, n);
        chk("force_pulse_len", n, 4);
        chk("force_no_retry", retry[2:0], 0);

        step(2);
        frc[0] = 1'b1;
        step(1);
        frc[0] = 1'b0;
        chk("holdoff_force_ign", rst_out[0], 0);
        chk("holdoff_hs_ign", up_out[0], 0);
        wait_for(1, 1'b1, 100, n);
        chk("holdoff_len", n, 8);

        frc[0] = 1'b1;
        step(1);
        frc[0] = 1'b0;
        chk("force2_rise", rst_out[0], 1);
        step(1);
        en[0] = 1'b0;
        step(1);
        chk("disable_drop", rst_out[0], 0);
        step(5);
        chk("disabled_rst", rst_out[0], 0);
        chk("disabled_up", up_out[0], 0);
        chk("disable_indep", up_out[1], 1);

        hs[0] = 1'b0;
        en[0] = 1'b1;
        wait_for(0, 1'b1, 1000, n);
        chk("reenable_timeout", n, 101);
        chk("reenable_retry", retry[2:0], 1);
        wait_for(0, 1'b0, 100, n);
        step(209);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("collide_rise", rst_out[0], 1);
        chk("collide_retry", retry[2:0], 0);
        wait_for(0, 1'b0, 100, n);
        wait_for(0, 1'b1, 1000, n);
        chk("post_collide_interval", n, 410);
        chk("post_collide_retry", retry[2:0], 1);
        wait_for(0, 1'b0, 100, n);
        step(60);

        rst_n = 1'b0;
        step(1);
        chk("midwait_rst_out", rst_out, 0);
        chk("midwait_up_out", up_out, 0);
        chk("midwait_retry", retry, 0);
        rst_n = 1'b1;
        wait_for(0, 1'b1, 1000, n);
        chk("post_reset_timeout", n, 101);
        chk("post_reset_link1", up_out[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
